// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a power-up clear sweep, registered read data,
// request-conflict/out-of-range pulses and saturating access counters.
module data_mem_responder #(
    parameter int DataWidth = 16,
    parameter int AddrBits  = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 MemRead,
    input  logic                 MemWrite,
    input  logic [DataWidth-1:0] MemAddr,
    input  logic [DataWidth-1:0] MemData,
    output logic [DataWidth-1:0] MemOutput,
    output logic                 Ready,
    output logic                 Conflict,
    output logic                 OutOfRange,
    input  logic [AddrBits-1:0]  dbg_addr,
    output logic [DataWidth-1:0] dbg_value,
    output logic [15:0]          rd_count,
    output logic [15:0]          wr_count
);
    localparam int Depth = 2 ** AddrBits;

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t                state;
    logic [AddrBits-1:0]   clrPtr;
    logic [DataWidth-1:0]  mem [Depth];
    logic [AddrBits-1:0]   wordIdx;
    logic                  addrHigh;
    logic                  doWrite;
    logic                  readReq;

    assign wordIdx   = MemAddr[AddrBits-1:0];
    assign addrHigh  = (MemAddr >> AddrBits) != '0;
    assign Ready     = (state == READY);
    assign doWrite   = Ready && MemWrite && !addrHigh;
    // A simultaneous write wins; the read half of the request is dropped.
    assign readReq   = Ready && MemRead && !MemWrite;
    assign dbg_value = mem[dbg_addr];

    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (state == CLEAR) begin
                mem[clrPtr] <= '0;
            end else if (doWrite) begin
                mem[wordIdx] <= MemData;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= CLEAR;
            clrPtr     <= '0;
            MemOutput  <= '0;
            Conflict   <= 1'b0;
            OutOfRange <= 1'b0;
            rd_count   <= '0;
            wr_count   <= '0;
        end else begin
            Conflict   <= 1'b0;
            OutOfRange <= 1'b0;
            unique case (state)
                CLEAR: begin
                    clrPtr <= clrPtr + AddrBits'(1);
                    if (clrPtr == '1) begin
                        state <= READY;
                    end
                end
                READY: begin
                    Conflict   <= MemRead && MemWrite;
                    OutOfRange <= (MemRead || MemWrite) && addrHigh;
                    if (doWrite && wr_count != '1) begin
                        wr_count <= wr_count + 16'd1;
                    end
                    if (readReq) begin
                        if (addrHigh) begin
                            MemOutput <= '0;
                        end else begin
                            MemOutput <= mem[wordIdx];
                            if (rd_count != '1) begin
                                rd_count <= rd_count + 16'd1;
                            end
                        end
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: reset/sweep timing, a vector table
// replayed through a scoreboard queue, mid-sweep reset and counter saturation.
module tb_data_mem_responder;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [15:0] MemAddr = '0;
    logic [15:0] MemData = '0;
    logic [15:0] MemOutput;
    logic        Ready;
    logic        Conflict;
    logic        OutOfRange;
    logic [7:0]  dbg_addr = '0;
    logic [15:0] dbg_value;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] expOut;
        logic        expConf;
        logic        expOor;
        logic [15:0] expRd;
        logic [15:0] expWr;
    } vec_t;

    vec_t vecs[13];
    vec_t sbq[$];

    data_mem_responder #(.DataWidth(16), .AddrBits(8)) dut (
        .CLK(CLK), .RST(RST), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemAddr(MemAddr), .MemData(MemData), .MemOutput(MemOutput),
        .Ready(Ready), .Conflict(Conflict), .OutOfRange(OutOfRange),
        .dbg_addr(dbg_addr), .dbg_value(dbg_value),
        .rd_count(rd_count), .wr_count(wr_count)
    );

    always #5 CLK = ~CLK;

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemAddr  = '0;
        MemData  = '0;
    endtask

    // Steps until Ready rises; returns edges taken (bounded).
    task automatic waitReady(output int n);
        n = 0;
        while (!Ready && n < 1000) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        bit clearLeak;
        logic [15:0] outBefore;
        vec_t v;
        vec_t e;

        vecs[0]  = '{1'b0, 1'b1, 16'h0002, 16'hFFEA, 16'h0000, 1'b0, 1'b0, 16'd0, 16'd1};
        vecs[1]  = '{1'b1, 1'b0, 16'h0002, 16'h0000, 16'hFFEA, 1'b0, 1'b0, 16'd1, 16'd1};
        vecs[2]  = '{1'b1, 1'b1, 16'h0005, 16'h0003, 16'hFFEA, 1'b1, 1'b0, 16'd1, 16'd2};
        vecs[3]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'hFFEA, 1'b0, 1'b0, 16'd1, 16'd2};
        vecs[4]  = '{1'b1, 1'b0, 16'h0005, 16'h0000, 16'h0003, 1'b0, 1'b0, 16'd2, 16'd2};
        vecs[5]  = '{1'b0, 1'b1, 16'h0104, 16'h1234, 16'h0003, 1'b0, 1'b1, 16'd2, 16'd2};
        vecs[6]  = '{1'b1, 1'b0, 16'h0104, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'd2, 16'd2};
        vecs[7]  = '{1'b1, 1'b0, 16'h0004, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'd3, 16'd2};
        vecs[8]  = '{1'b1, 1'b1, 16'h0200, 16'h0007, 16'h0000, 1'b1, 1'b1, 16'd3, 16'd2};
        vecs[9]  = '{1'b0, 1'b1, 16'h00FF, 16'hA5A5, 16'h0000, 1'b0, 1'b0, 16'd3, 16'd3};
        vecs[10] = '{1'b1, 1'b0, 16'h00FF, 16'h0000, 16'hA5A5, 1'b0, 1'b0, 16'd4, 16'd3};
        vecs[11] = '{1'b0, 1'b1, 16'h0002, 16'h1111, 16'hA5A5, 1'b0, 1'b0, 16'd4, 16'd4};
        vecs[12] = '{1'b1, 1'b0, 16'h0002, 16'h0000, 16'h1111, 1'b0, 1'b0, 16'd5, 16'd4};

        // Reset held for two edges
        RST = 1'b1;
        idle();
        step();
        step();
        chk("rst_ready", 32'(Ready), 32'd0);
        chk("rst_out", 32'(MemOutput), 32'h0);
        chk("rst_conf_oor", {30'd0, Conflict, OutOfRange}, 32'd0);
        chk("rst_counts", {rd_count, wr_count}, 32'd0);

        RST = 1'b0;
        waitReady(n);
        chk("sweep_len", 32'(n), 32'd256);
        dbg_addr = 8'd0;   #1 chk("dbg_0", 32'(dbg_value), 32'h0);
        dbg_addr = 8'd128; #1 chk("dbg_128", 32'(dbg_value), 32'h0);
        dbg_addr = 8'd255; #1 chk("dbg_255", 32'(dbg_value), 32'h0);

        for (int i = 0; i < 13; i++) begin
            v = vecs[i];
            MemRead  = v.rd;
            MemWrite = v.wr;
            MemAddr  = v.addr;
            MemData  = v.data;
            sbq.push_back(v);
            step();
            e = sbq.pop_front();
            chk($sformatf("v%0d_out", i), 32'(MemOutput), 32'(e.expOut));
            chk($sformatf("v%0d_pulses", i), {30'd0, Conflict, OutOfRange}, {30'd0, e.expConf, e.expOor});
            chk($sformatf("v%0d_counts", i), {rd_count, wr_count}, {e.expRd, e.expWr});
            if (i == 2) begin
                dbg_addr = 8'd5;
                #1 chk("conflict_write_mem5", 32'(dbg_value), 32'h3);
            end
        end
        idle();
        dbg_addr = 8'd4;
        #1 chk("oor_mem4_untouched", 32'(dbg_value), 32'h0);
        chk("queue_drained", 32'(sbq.size()), 32'd0);

        // Reset from READY, then reset again mid-sweep with traffic on that edge
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("rerst_counts", {rd_count, wr_count}, 32'd0);
        chk("rerst_ready", 32'(Ready), 32'd0);
        for (int i = 0; i < 100; i++) step();
        RST = 1'b1;
        MemWrite = 1'b1;
        MemAddr  = 16'h0003;
        MemData  = 16'h0009;
        step();
        RST = 1'b0;
        chk("mid_rst_ready", 32'(Ready), 32'd0);
        clearLeak = 1'b0;
        outBefore = MemOutput;
        n = 0;
        while (!Ready && n < 1000) begin
            MemRead  = n[0];
            MemWrite = 1'b1;
            MemAddr  = (n < 8) ? 16'h0003 : 16'h0103;
            MemData  = 16'hBEEF;
            step();
            n++;
            if (Conflict || OutOfRange || MemOutput !== outBefore || rd_count != 0 || wr_count != 0)
                clearLeak = 1'b1;
        end
        idle();
        chk("mid_sweep_len", 32'(n), 32'd256);
        chk("clear_ignores_req", 32'(clearLeak), 32'd0);
        chk("mid_counts", {rd_count, wr_count}, 32'd0);
        dbg_addr = 8'd3;   #1 chk("clear_mem3", 32'(dbg_value), 32'h0);
        dbg_addr = 8'd255; #1 chk("clear_mem255", 32'(dbg_value), 32'h0);

        // Write counter saturation
        for (int i = 0; i < 65534; i++) begin
            MemWrite = 1'b1;
            MemAddr  = 16'h0007;
            MemData  = i[15:0];
            step();
        end
        chk("wr_preload", 32'(wr_count), 32'hFFFE);
        for (int i = 0; i < 3; i++) begin
            MemWrite = 1'b1;
            MemAddr  = 16'h0007;
            MemData  = 16'hC0DE;
            step();
            chk($sformatf("wr_sat%0d", i), 32'(wr_count), 32'hFFFF);
        end
        idle();
        dbg_addr = 8'd7;
        #1 chk("sat_last_data", 32'(dbg_value), 32'hC0DE);
        chk("sat_rd_count", 32'(rd_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
